alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Holds one decoded operation and resolves operand hazards.
- Presents `input_a`, `input_b` and the 5-bit ALU op code (constants from `format.vh`) to the ALU under a valid/ready handshake.
- Forwards results from EX/MEM and MEM/WB, and inserts bubbles on load-use hazards.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-index width.
- OP_W, 5, ALU op code width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decode offers an operation.
- in_ready  out  1  stage accepts this cycle.
- in_alu_op  in  OP_W  ALU op code (IADD, ISUB, ILT, ...).
- in_rs1, in_rs2, in_rd  in  RA_W  register indices.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm, in_pc  in  XLEN  immediate and pc.
- in_use_pc  in  1  operand A = pc; rs1 unused.
- in_use_imm  in  1  operand B = imm; rs2 unused.
- in_reg_write, in_is_load  in  1  op writes rd; op is a load.
- flush  in  1  kill held op (branch redirect).
- exm_rd  in  RA_W  EX/MEM destination.
- exm_reg_write, exm_is_load  in  1  EX/MEM write/load flags.
- exm_result  in  XLEN  EX/MEM result.
- wb_rd  in  RA_W  MEM/WB destination.
- wb_reg_write  in  1  MEM/WB write flag.
- wb_data  in  XLEN  MEM/WB data.
- out_valid  out  1  op presented to ALU.
- out_ready  in  1  EX consumes.
- input_a, input_b  out  XLEN  ALU operands.
- out_alu_op  out  OP_W  to ALU instruction input.
- out_rd  out  RA_W  destination index.
- out_reg_write, out_is_load  out  1  control flags.

Behaviour:
- Reset: state EMPTY. All held registers zero. `out_valid=0`; `input_a`, `input_b`, `out_alu_op`, `out_rd` and flags all 0. `in_ready=1` from the first cycle after reset.
- States:
  - EMPTY: no op held.
  - FULL: op held, no hazard.
  - HAZARD: op held, load-use pending.
- Next state is recomputed every cycle from the held op and the current EX/MEM bus.
- Source match rules:
  - rs1 matches r when `!use_pc && rs1==r && r!=0`.
  - rs2 matches r when `!use_imm && rs2==r && r!=0`.
- Hazard: `exm_reg_write && exm_is_load` and either source matches `exm_rd`.
- Operand mux, combinational; priority is EX/MEM (non-load) > MEM/WB > held data. A pc/imm select overrides all.
- `out_valid` = held op and no hazard; it is high only in FULL.
- Transfers:
  - Output transfer = `out_valid && out_ready`.
  - `in_ready` = `!flush && (EMPTY || output transfer)`.
  - Input transfer = `in_valid && in_ready`; it captures all `in_*` fields.
  - Latency: capture edge -> presented next cycle (1 cycle) when hazard-free.
- Write-back snoop: every cycle an op is held, if `wb_reg_write` and `wb_rd` matches a used source, that held data register is overwritten with `wb_data`.
  - Stalled operands therefore never go stale once the writer retires.
  - A capture in the same cycle takes the snooped `wb_data`, not `in_rs*_data`.
- Simultaneous output and input transfer: new op replaces old, no bubble.
- Flush has priority over everything:
  - State goes to EMPTY next cycle.
  - No capture in the flush cycle.
  - `out_valid` stays as computed in the flush cycle; EX also discards on flush.
- Reset mid-operation: held op dropped, no output transfer on the following cycle.
- Outputs stay stable while `out_valid && !out_ready`.
- HAZARD releases automatically once EX/MEM no longer holds the matching load.

Optional Feature:
- ALU_ISSUE_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding paths.
  - Any match against an EX/MEM write (`exm_reg_write`), load or not, is a hazard.
  - The op stalls in HAZARD until the writer reaches MEM/WB and the snoop updates the held data.
  - Operands always come from held registers.

Decomposition:
- Shared header `src/Modules/format.vh` holds the ALU op codes (IADD, ISUB, IAND, IOR, IXOR, IPAS, ILT, ILTU, IGE, IGEU, IEQ, INE) and the state encodings `ST_EMPTY`, `ST_FULL`, `ST_HAZARD`.
- One natural sub-module, `fwd_mux`: combinational per-operand source select. It is instantiated twice.

Test Plan:
- IADD, rs1=3 (data 5), rs2=4 (data 7), no in-flight writers -> next cycle `out_valid=1`, `input_a=5`, `input_b=7`, `out_alu_op=IADD`.
- Held op rs1=3 while exm_rd=3, `exm_reg_write=1`, non-load, result 0x10 -> `input_a=0x10`. Same with `wb_rd=3` also writing 0x20 -> EX/MEM wins, 0x10.
- Load-use: `exm_is_load=1`, exm_rd=4, held rs2=4 -> `out_valid=0` for one cycle. Next cycle `wb_rd=4`, `wb_data=0x99` -> `out_valid=1`, `input_b=0x99`.
- `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0`, outputs unchanged. `out_ready=1` -> back-to-back transfer, new op presented next cycle.
- `flush=1` while FULL and `in_valid=1` -> no capture, `out_valid=0` next cycle. rs1=0 with exm_rd=0 written -> no forward, no stall.
- Macro undefined: exm non-load write to rd=3, held rs1=3 -> stall until the MEM/WB snoop, then `input_a` equals the snooped value.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared ALU op codes and issue-stage state encodings
//
// Purpose: constants shared by the ALU issue stage and its users.
//   ALU op codes (5 bits): IADD, ISUB, IAND, IOR, IXOR, IPAS, ILT, ILTU,
//   IGE, IGEU, IEQ, INE.
//   Issue-stage states: ST_EMPTY, ST_FULL, ST_HAZARD.
package alu_issue_pkg;

  localparam logic [4:0] IADD = 5'd0;
  localparam logic [4:0] ISUB = 5'd1;
  localparam logic [4:0] IAND = 5'd2;
  localparam logic [4:0] IOR  = 5'd3;
  localparam logic [4:0] IXOR = 5'd4;
  localparam logic [4:0] IPAS = 5'd5;
  localparam logic [4:0] ILT  = 5'd6;
  localparam logic [4:0] ILTU = 5'd7;
  localparam logic [4:0] IGE  = 5'd8;
  localparam logic [4:0] IGEU = 5'd9;
  localparam logic [4:0] IEQ  = 5'd10;
  localparam logic [4:0] INE  = 5'd11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HAZARD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// rtl/alu_issue_fwd_mux.sv - per-operand source select for the ALU issue stage
//
// Purpose: pick one ALU operand from pc/imm, EX/MEM result, MEM/WB data or
// the held register value, and report which in-flight writers match it.
// Ports:
//   sel_alt, alt_val        operand replaced by pc/imm; register source unused
//   src, held_val           register index and held read data
//   exm_rd/_reg_write       EX/MEM writer; exm_fwd_en allows taking exm_result
//   wb_rd/_reg_write        MEM/WB writer; wb_fwd_en allows taking wb_data
//   exm_hit, wb_hit         writer targets this operand's register source
//   operand                 selected operand value
module alu_issue_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            sel_alt,
  input  logic [XLEN-1:0] alt_val,
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] held_val,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic            exm_fwd_en,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            wb_fwd_en,
  input  logic [XLEN-1:0] wb_data,
  output logic            exm_hit,
  output logic            wb_hit,
  output logic [XLEN-1:0] operand
);

  // x0 is never a real dependency, and a pc/imm operand has no register source.
  assign exm_hit = exm_reg_write && !sel_alt && (src == exm_rd) && (exm_rd != '0);
  assign wb_hit  = wb_reg_write  && !sel_alt && (src == wb_rd)  && (wb_rd  != '0);

  // The younger writer (EX/MEM) wins over MEM/WB.
  always_comb begin
    operand = held_val;
    if (sel_alt)
      operand = alt_val;
    else if (exm_fwd_en && exm_hit)
      operand = exm_result;
    else if (wb_fwd_en && wb_hit)
      operand = wb_data;
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ID/EX issue stage with operand forwarding and hazard stall
//
// Purpose: hold one decoded op, resolve operand hazards and present operands
// to the ALU under a valid/ready handshake.
// Build option: ALU_ISSUE_FORWARD_EN
//   defined   - EX/MEM (non-load) and MEM/WB forwarding; only load-use stalls.
//   undefined - no forwarding; any pending EX/MEM or MEM/WB write to a used
//               source stalls until the MEM/WB snoop has refreshed held data.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready + in_*          decoded op from decode
//   flush                             drop held op, block capture
//   exm_*                             EX/MEM writer bus
//   wb_*                              MEM/WB writer bus
//   out_valid/out_ready               handshake to the ALU
//   input_a, input_b, out_alu_op, out_rd, out_reg_write, out_is_load
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_alu_op,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_use_pc,
  input  logic            in_use_imm,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic            flush,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic            exm_is_load,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] input_a,
  output logic [XLEN-1:0] input_b,
  output logic [OP_W-1:0] out_alu_op,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_is_load
);

`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Registered state only distinguishes EMPTY/FULL; HAZARD is an overlay
  // re-evaluated each cycle against the live EX/MEM and MEM/WB buses.
  state_t          st_q;
  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] d1_q, d2_q, imm_q, pc_q;
  logic            use_pc_q, use_imm_q, rw_q, ld_q;

  logic a_exm, a_wb, b_exm, b_wb;
  logic exm_fwd_en;
  logic stall;
  logic out_fire, in_fire;
  logic cap_wb1, cap_wb2;

  assign exm_fwd_en = FWD_EN && !exm_is_load;

  alu_issue_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
    .sel_alt(use_pc_q), .alt_val(pc_q), .src(rs1_q), .held_val(d1_q),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_fwd_en(exm_fwd_en),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_fwd_en(FWD_EN), .wb_data(wb_data),
    .exm_hit(a_exm), .wb_hit(a_wb), .operand(input_a)
  );

  alu_issue_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
    .sel_alt(use_imm_q), .alt_val(imm_q), .src(rs2_q), .held_val(d2_q),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_fwd_en(exm_fwd_en),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_fwd_en(FWD_EN), .wb_data(wb_data),
    .exm_hit(b_exm), .wb_hit(b_wb), .operand(input_b)
  );

  // Without forwarding, a MEM/WB match also stalls: held data only becomes
  // correct after the snoop edge at the end of that cycle.
  always_comb begin
    if (FWD_EN)
      stall = exm_is_load && (a_exm || b_exm);
    else
      stall = a_exm || b_exm || a_wb || b_wb;
    state = st_q;
    if (st_q != ST_EMPTY && stall)
      state = ST_HAZARD;
  end

  assign out_valid = (state == ST_FULL);
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !flush && ((st_q == ST_EMPTY) || out_fire);
  assign in_fire   = in_valid && in_ready;

  // Incoming op whose source is being written back this cycle: the register
  // file read is stale, take the write-back value instead.
  assign cap_wb1 = wb_reg_write && !in_use_pc  && (in_rs1 == wb_rd) && (wb_rd != '0);
  assign cap_wb2 = wb_reg_write && !in_use_imm && (in_rs2 == wb_rd) && (wb_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_EMPTY;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      use_pc_q  <= 1'b0;
      use_imm_q <= 1'b0;
      rw_q      <= 1'b0;
      ld_q      <= 1'b0;
    end else if (flush) begin
      st_q <= ST_EMPTY;
    end else if (in_fire) begin
      st_q      <= ST_FULL;
      op_q      <= in_alu_op;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rd_q      <= in_rd;
      d1_q      <= cap_wb1 ? wb_data : in_rs1_data;
      d2_q      <= cap_wb2 ? wb_data : in_rs2_data;
      imm_q     <= in_imm;
      pc_q      <= in_pc;
      use_pc_q  <= in_use_pc;
      use_imm_q <= in_use_imm;
      rw_q      <= in_reg_write;
      ld_q      <= in_is_load;
    end else begin
      if (out_fire)
        st_q <= ST_EMPTY;
      // Keep stalled operands fresh as their writers retire.
      if (st_q != ST_EMPTY && a_wb)
        d1_q <= wb_data;
      if (st_q != ST_EMPTY && b_wb)
        d2_q <= wb_data;
    end
  end

  assign out_alu_op    = op_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign out_is_load   = ld_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_alu_op, in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_pc, in_use_imm, in_reg_write, in_is_load;
  logic        flush;
  logic [4:0]  exm_rd;
  logic        exm_reg_write, exm_is_load;
  logic [31:0] exm_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] input_a, input_b;
  logic [4:0]  out_alu_op, out_rd;
  logic        out_reg_write, out_is_load;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .input_a(input_a), .input_b(input_b), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_load(out_is_load)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: the op the stage should be holding ----
  typedef struct packed {
    logic        v;
    logic [4:0]  op, rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        upc, uimm, rw, ld;
  } held_t;

  held_t m;
  logic  e1, e2, w1, w2, stall_m, exp_ov, exp_ir;
  logic [31:0] exp_a, exp_b;

  // Does an in-flight write to register r feed this operand?
  function automatic logic feeds(input logic no_reg, input logic [4:0] idx, input logic [4:0] r);
    return !no_reg && (idx == r) && (r != 5'd0);
  endfunction

  always_comb begin
    e1 = exm_reg_write && feeds(m.upc,  m.rs1, exm_rd);
    e2 = exm_reg_write && feeds(m.uimm, m.rs2, exm_rd);
    w1 = wb_reg_write  && feeds(m.upc,  m.rs1, wb_rd);
    w2 = wb_reg_write  && feeds(m.uimm, m.rs2, wb_rd);
`ifdef ALU_ISSUE_FORWARD_EN
    stall_m = exm_is_load && (e1 || e2);
    exp_a = m.upc  ? m.pc  : (e1 && !exm_is_load) ? exm_result : w1 ? wb_data : m.d1;
    exp_b = m.uimm ? m.imm : (e2 && !exm_is_load) ? exm_result : w2 ? wb_data : m.d2;
`else
    stall_m = e1 || e2 || w1 || w2;
    exp_a = m.upc  ? m.pc  : m.d1;
    exp_b = m.uimm ? m.imm : m.d2;
`endif
    exp_ov = m.v && !stall_m;
    exp_ir = !flush && (!m.v || (exp_ov && out_ready));
  end

  function automatic held_t model_next(input held_t c);
    held_t n;
    n = c;
    if (flush) begin
      n.v = 1'b0;
    end else if (in_valid && exp_ir) begin
      n.v = 1'b1; n.op = in_alu_op; n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd;
      n.d1 = (wb_reg_write && feeds(in_use_pc,  in_rs1, wb_rd)) ? wb_data : in_rs1_data;
      n.d2 = (wb_reg_write && feeds(in_use_imm, in_rs2, wb_rd)) ? wb_data : in_rs2_data;
      n.imm = in_imm; n.pc = in_pc; n.upc = in_use_pc; n.uimm = in_use_imm;
      n.rw = in_reg_write; n.ld = in_is_load;
    end else begin
      if (exp_ov && out_ready) n.v = 1'b0;
      if (c.v && w1) n.d1 = wb_data;
      if (c.v && w2) n.d2 = wb_data;
    end
    return n;
  endfunction

  always @(posedge clk) m <= rst ? '0 : model_next(m);

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        chk("input_a", input_a, exp_a);
        chk("input_b", input_b, exp_b);
        chk("out_alu_op", {27'd0, out_alu_op}, {27'd0, m.op});
        chk("out_rd", {27'd0, out_rd}, {27'd0, m.rd});
        chk("out_flags", {30'd0, out_reg_write, out_is_load}, {30'd0, m.rw, m.ld});
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_bus();
    exm_rd = '0; exm_reg_write = 0; exm_is_load = 0; exm_result = '0;
    wb_rd = '0; wb_reg_write = 0; wb_data = '0;
  endtask

  task automatic offer(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1; in_alu_op = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = '0; in_pc = '0;
    in_use_pc = 0; in_use_imm = 0; in_reg_write = 1; in_is_load = 0;
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 0;
    offer(IADD, 0, 0, 0, 0, 0);
    in_valid = 0; in_reg_write = 0;
    clear_bus();
    tick(); tick();
    rst = 0; run = 1'b1;

    // reset state
    settle();
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst input_a", input_a, 32'd0);
    chk("rst input_b", input_b, 32'd0);
    chk("rst op/rd/flags", {out_alu_op, out_rd, out_reg_write, out_is_load}, 32'd0);

    // plain IADD, 1-cycle latency
    offer(IADD, 3, 4, 1, 32'd5, 32'd7);
    tick();
    in_valid = 0;
    settle();
    chk("iadd valid", {31'd0, out_valid}, 32'd1);
    chk("iadd a", input_a, 32'd5);
    chk("iadd b", input_b, 32'd7);
    chk("iadd op", {27'd0, out_alu_op}, {27'd0, IADD});

    // EX/MEM non-load writer of rs1, then also MEM/WB writer
    exm_rd = 3; exm_reg_write = 1; exm_result = 32'h10;
    settle();
`ifdef ALU_ISSUE_FORWARD_EN
    chk("exm fwd a", input_a, 32'h10);
`else
    chk("exm stall", {31'd0, out_valid}, 32'd0);
`endif
    tick();
    wb_rd = 3; wb_reg_write = 1; wb_data = 32'h20;
    settle();
`ifdef ALU_ISSUE_FORWARD_EN
    chk("exm beats wb", input_a, 32'h10);
`else
    chk("exm+wb stall", {31'd0, out_valid}, 32'd0);
`endif
    tick();
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    settle();
`ifdef ALU_ISSUE_FORWARD_EN
    chk("wb fwd a", input_a, 32'h20);
`else
    chk("wb snoop stall", {31'd0, out_valid}, 32'd0);
`endif
    tick();
    clear_bus();
    out_ready = 1;
    settle();
    chk("snooped a", input_a, 32'h20);
    chk("snooped valid", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 0;

    // load-use on rs2
    offer(ISUB, 5, 4, 6, 32'h11, 32'h44);
    tick();
    in_valid = 0;
    exm_rd = 4; exm_reg_write = 1; exm_is_load = 1; exm_result = 32'hBAD;
    settle();
    chk("load-use stall", {31'd0, out_valid}, 32'd0);
    tick();
    clear_bus();
    wb_rd = 4; wb_reg_write = 1; wb_data = 32'h99;
    settle();
`ifdef ALU_ISSUE_FORWARD_EN
    chk("load-use release b", input_b, 32'h99);
`else
    chk("load-use wb stall", {31'd0, out_valid}, 32'd0);
`endif
    tick();
    clear_bus();
    settle();
    chk("load-use b", input_b, 32'h99);
    chk("load-use a", input_a, 32'h11);

    // backpressure with a waiting op, then back-to-back transfer
    offer(IXOR, 7, 8, 9, 32'hF0, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp op held", {27'd0, out_alu_op}, {27'd0, ISUB});
      chk("bp b held", input_b, 32'h99);
      tick();
    end
    out_ready = 1;
    settle();
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 0; out_ready = 0;
    settle();
    chk("b2b op", {27'd0, out_alu_op}, {27'd0, IXOR});
    chk("b2b a", input_a, 32'hF0);
    chk("b2b rd", {27'd0, out_rd}, 32'd9);

    // flush while FULL with an offered op
    flush = 1; out_ready = 1;
    offer(IOR, 1, 2, 3, 32'hAA, 32'hBB);
    settle();
    chk("flush in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    settle();
    chk("post-flush valid", {31'd0, out_valid}, 32'd0);
    chk("post-flush in_ready", {31'd0, in_ready}, 32'd1);

    // x0 never forwards or stalls
    offer(IAND, 0, 2, 5, 32'h123, 32'h456);
    tick();
    in_valid = 0;
    exm_rd = 0; exm_reg_write = 1; exm_result = 32'hDEAD;
    wb_rd = 0; wb_reg_write = 1; wb_data = 32'hBEEF;
    settle();
    chk("x0 valid", {31'd0, out_valid}, 32'd1);
    chk("x0 a", input_a, 32'h123);
    tick();
    clear_bus();
    out_ready = 1;
    settle();
    chk("x0 no snoop", input_a, 32'h123);
    tick();
    out_ready = 0;

    // pc/imm operands ignore writers; capture-cycle snoop of the next op
    offer(IADD, 3, 4, 2, 32'h5, 32'h6);
    in_use_pc = 1; in_pc = 32'h1000; in_use_imm = 1; in_imm = 32'h8;
    tick();
    exm_rd = 3; exm_reg_write = 1; exm_is_load = 1;
    wb_rd = 5; wb_reg_write = 1; wb_data = 32'h77;
    out_ready = 1;
    offer(IPAS, 5, 6, 7, 32'h1, 32'h2);
    settle();
    chk("pc/imm valid", {31'd0, out_valid}, 32'd1);
    chk("pc a", input_a, 32'h1000);
    chk("imm b", input_b, 32'h8);
    tick();
    clear_bus();
    in_valid = 0; out_ready = 0;
    settle();
    chk("cap snoop a", input_a, 32'h77);
    chk("cap snoop b", input_b, 32'h2);

    // reset while holding an op
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("mid-rst valid", {31'd0, out_valid}, 32'd0);
    chk("mid-rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid-rst a", input_a, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
